// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM and the cache-side initiator that drives it.
package burst_ram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_IDLE        = 3'd1,
        ST_READ_WAIT   = 3'd2,
        ST_READ_BURST  = 3'd3,
        ST_WRITE_BURST = 3'd4
    } state_t;

endpackage

// File: rtl/burst_ram_if.sv
// Command/data bus between a burst initiator (master) and the burst RAM (slave).
interface burst_ram_if #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64
);
    logic                          cmd;
    logic                          cmd_en;
    logic [DEPTH_BITWIDTH-1:0]     addr;
    logic [DATA_BITWIDTH-1:0]      wr_data;
    logic [DATA_BITWIDTH/8-1:0]    data_mask;
    logic [DATA_BITWIDTH-1:0]      rd_data;
    logic                          rd_data_valid;
    logic                          busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface

// File: rtl/burst_ram_array.sv
// Single-port word memory split into byte lanes; per-byte write enable, registered read.
module burst_ram_array #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic                        re,
    input  logic [DEPTH_BITWIDTH-1:0]   addr,
    input  logic [DATA_BITWIDTH-1:0]    wdata,
    input  logic [DATA_BITWIDTH/8-1:0]  mask,
    output logic [DATA_BITWIDTH-1:0]    rdata
);
    localparam int WORDS = 1 << DEPTH_BITWIDTH;
    localparam int LANES = DATA_BITWIDTH / 8;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            logic [7:0] q_reg;

            // Storage is never reset; only the output register is.
            always_ff @(posedge clk) begin
                if (we && !mask[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= 8'd0;
                end else if (re) begin
                    q_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate
endmodule

// File: rtl/burst_ram.sv
// Burst RAM controller: accepts read/write burst commands, steps the word address
// with wrap-around, and sequences latency and beat counters around burst_ram_array.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4,
    parameter int READ_LATENCY   = 3,
    parameter int INIT_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    burst_ram_if.slave bus
);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int BEAT_W = $clog2(BURST_COUNT + 1);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT - 1);

    state_t                    state_reg, state_next;
    logic [INIT_W-1:0]         init_cnt_reg, init_cnt_next;
    logic [LAT_W-1:0]          lat_cnt_reg, lat_cnt_next;
    logic [BEAT_W-1:0]         beat_cnt_reg, beat_cnt_next;
    logic [DEPTH_BITWIDTH-1:0] addr_reg, addr_next;
    logic                      rd_valid_reg;

    logic                      busy;
    logic                      accept;
    logic                      mem_we, mem_re;
    logic [DEPTH_BITWIDTH-1:0] mem_addr;

    // Busy stays high through the last read beat so it falls together with rd_data_valid.
    assign busy          = (state_reg != ST_IDLE) || rd_valid_reg;
    assign accept        = bus.cmd_en && !busy;
    assign bus.busy      = busy;
    assign bus.rd_data_valid = rd_valid_reg;

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        lat_cnt_next  = lat_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        addr_next     = addr_reg;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_addr      = addr_reg;

        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == INIT_LAST) begin
                    init_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    init_cnt_next = init_cnt_reg + INIT_W'(1);
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    if (bus.cmd == CMD_WRITE) begin
                        // Beat 0 is written on the accepting edge itself.
                        mem_we   = 1'b1;
                        mem_addr = bus.addr;
                        if (BURST_COUNT > 1) begin
                            beat_cnt_next = BEAT_W'(1);
                            addr_next     = bus.addr + DEPTH_BITWIDTH'(1);
                            state_next    = ST_WRITE_BURST;
                        end
                    end else begin
                        beat_cnt_next = '0;
                        lat_cnt_next  = '0;
                        addr_next     = bus.addr;
                        state_next    = (READ_LATENCY > 1) ? ST_READ_WAIT : ST_READ_BURST;
                    end
                end
            end

            ST_READ_WAIT: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    lat_cnt_next = '0;
                    state_next   = ST_READ_BURST;
                end else begin
                    lat_cnt_next = lat_cnt_reg + LAT_W'(1);
                end
            end

            ST_READ_BURST: begin
                mem_re    = 1'b1;
                addr_next = addr_reg + DEPTH_BITWIDTH'(1);
                if (beat_cnt_reg == BEAT_LAST) begin
                    beat_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
            end

            ST_WRITE_BURST: begin
                mem_we    = 1'b1;
                addr_next = addr_reg + DEPTH_BITWIDTH'(1);
                if (beat_cnt_reg == BEAT_LAST) begin
                    beat_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            lat_cnt_reg  <= '0;
            beat_cnt_reg <= '0;
            addr_reg     <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            lat_cnt_reg  <= lat_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            addr_reg     <= addr_next;
            rd_valid_reg <= (state_reg == ST_READ_BURST);
        end
    end

    // An edge with rst high must not touch memory, so aborted bursts stop cleanly.
    burst_ram_array #(
        .DEPTH_BITWIDTH (DEPTH_BITWIDTH),
        .DATA_BITWIDTH  (DATA_BITWIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we && !rst),
        .re    (mem_re && !rst),
        .addr  (mem_addr),
        .wdata (bus.wr_data),
        .mask  (bus.data_mask),
        .rdata (bus.rd_data)
    );
endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: randomized bursts against a word-array reference model.
module tb_burst_ram;
    import burst_ram_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int MW    = DW / 8;
    localparam int BC    = 4;
    localparam int RL    = 3;
    localparam int IC    = 16;
    localparam int WORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    burst_ram_if #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW)) bus ();

    burst_ram #(
        .DEPTH_BITWIDTH (AW),
        .DATA_BITWIDTH  (DW),
        .BURST_COUNT    (BC),
        .READ_LATENCY   (RL),
        .INIT_CYCLES    (IC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_mem [WORDS];
    logic [DW-1:0] wd [BC];
    logic [MW-1:0] wm [BC];

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // Byte-granular model update: a set mask bit keeps the old byte.
    task automatic model_write(input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        for (int b = 0; b < MW; b++) begin
            if (!m[b]) model_mem[a % WORDS][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Returns just after a negedge with busy low, or records a timeout.
    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL wait_ready: busy=%0b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic do_write(input int a, input int nbeats);
        wait_ready();
        for (int k = 0; k < nbeats; k++) begin
            bus.cmd_en    = (k == 0);
            bus.cmd       = CMD_WRITE;
            bus.addr      = AW'(a);
            bus.wr_data   = wd[k];
            bus.data_mask = wm[k];
            @(posedge clk);
            model_write(a + k, wd[k], wm[k]);
            @(negedge clk);
            bus.cmd_en = 1'b0;
            checks++;
            if (bus.busy !== (k < BC - 1)) begin
                failures++;
                $display("FAIL write_busy: addr=%0d beat=%0d busy=%0b required %0b", a, k, bus.busy, (k < BC - 1));
            end
            checks++;
            if (bus.rd_data_valid !== 1'b0) begin
                failures++;
                $display("FAIL write_valid: addr=%0d beat=%0d rd_data_valid=%0b required 0", a, k, bus.rd_data_valid);
            end
        end
        $display("write addr=%0d beats=%0d", a, nbeats);
    endtask

    // Checks the whole read timeline cycle by cycle; poke drives ignored commands while busy.
    task automatic do_read(input int a, input bit poke);
        logic          exp_valid, exp_busy;
        logic [DW-1:0] exp_data;
        wait_ready();
        bus.cmd_en = 1'b1;
        bus.cmd    = CMD_READ;
        bus.addr   = AW'(a);
        for (int i = 1; i <= RL + BC + 2; i++) begin
            @(negedge clk);
            if (poke && i >= 2 && i < RL + BC) begin
                bus.cmd_en    = 1'b1;
                bus.cmd       = ($urandom_range(0, 1) == 1) ? CMD_WRITE : CMD_READ;
                bus.addr      = AW'($urandom);
                bus.wr_data   = rand_word();
                bus.data_mask = '0;
            end else begin
                bus.cmd_en = 1'b0;
            end
            exp_valid = (i > RL) && (i <= RL + BC);
            exp_busy  = (i <= RL + BC);
            checks++;
            if (bus.rd_data_valid !== exp_valid) begin
                failures++;
                $display("FAIL read_valid: addr=%0d cycle=%0d rd_data_valid=%0b required %0b", a, i, bus.rd_data_valid, exp_valid);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                failures++;
                $display("FAIL read_busy: addr=%0d cycle=%0d busy=%0b required %0b", a, i, bus.busy, exp_busy);
            end
            if (i > RL) begin
                exp_data = exp_valid ? model_mem[(a + i - RL - 1) % WORDS] : model_mem[(a + BC - 1) % WORDS];
                checks++;
                if (bus.rd_data !== exp_data) begin
                    failures++;
                    $display("FAIL read_data: addr=%0d cycle=%0d rd_data=%h required %h", a, i, bus.rd_data, exp_data);
                end
            end
        end
        $display("read addr=%0d poke=%0b", a, poke);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.cmd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_en    = 1'b0;
        bus.cmd       = CMD_READ;
        bus.addr      = '0;
        bus.wr_data   = '0;
        bus.data_mask = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.rd_data !== '0) begin
            failures++;
            $display("FAIL reset_rd_data: rd_data=%h required 0", bus.rd_data);
        end
        rst = 1'b0;
        for (int i = 0; i < IC + 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.busy !== (i < IC)) begin
                failures++;
                $display("FAIL reset_busy: cycle=%0d busy=%0b required %0b", i, bus.busy, (i < IC));
            end
            checks++;
            if (bus.rd_data_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid: cycle=%0d rd_data_valid=%0b required 0", i, bus.rd_data_valid);
            end
        end
        $display("reset busy window checked");
    endtask

    task automatic test_preload();
        for (int a = 0; a < WORDS; a += BC) begin
            for (int k = 0; k < BC; k++) begin
                wd[k] = rand_word();
                wm[k] = '0;
            end
            do_write(a, BC);
        end
        for (int a = 0; a < WORDS; a += BC) do_read(a, 1'b0);
    endtask

    task automatic test_directed();
        logic [7:0] b;
        for (int k = 0; k < BC; k++) begin
            b     = 8'(8'h11 * (k + 1));
            wd[k] = {MW{b}};
            wm[k] = '0;
        end
        do_write(2, BC);
        do_read(2, 1'b0);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < BC; k++) begin
            wd[k] = rand_word();
            wm[k] = '0;
        end
        do_write(WORDS - 2, BC);
        do_read(0, 1'b0);
        do_read(WORDS - 2, 1'b0);
    endtask

    task automatic test_mask();
        for (int k = 0; k < BC; k++) begin
            wd[k] = '1;
            wm[k] = '0;
        end
        do_write(5, BC);
        wd[0] = '0;
        wm[0] = 8'hF0;
        for (int k = 1; k < BC; k++) begin
            wd[k] = rand_word();
            wm[k] = '1;
        end
        do_write(5, BC);
        do_read(5, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < BC; k++) begin
                    wd[k] = rand_word();
                    wm[k] = MW'($urandom);
                end
                do_write($urandom_range(0, WORDS - 1), BC);
            end else begin
                do_read($urandom_range(0, WORDS - 1), 1'b0);
            end
        end
    endtask

    task automatic test_ignore_busy();
        do_read(3, 1'b1);
        do_read(7, 1'b1);
        do_read(0, 1'b0);
        do_read(8, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < BC; k++) begin
                wd[k] = rand_word();
                wm[k] = MW'($urandom);
            end
            do_write((n * 5) % WORDS, BC);
        end
        do_read(0, 1'b0);
        do_read(5, 1'b0);
        do_read(10, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        wait_ready();
        bus.cmd_en = 1'b1;
        bus.cmd    = CMD_READ;
        bus.addr   = AW'(9);
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk);
            bus.cmd_en = 1'b0;
        end
        pulse_reset();
        checks++;
        if (bus.rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL midread_valid: rd_data_valid=%0b required 0", bus.rd_data_valid);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midread_busy: busy=%0b required 1", bus.busy);
        end
        checks++;
        if (bus.rd_data !== '0) begin
            failures++;
            $display("FAIL midread_rd_data: rd_data=%h required 0", bus.rd_data);
        end
        $display("reset during read checked");
        do_read(9, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        for (int k = 0; k < BC; k++) begin
            wd[k] = rand_word();
            wm[k] = '0;
        end
        do_write(12, 2);
        bus.wr_data = rand_word();
        pulse_reset();
        $display("reset during write applied after 2 beats");
        do_read(12, 1'b0);
        do_read(14, 1'b0);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_directed();
        test_wrap();
        test_mask();
        test_ignore_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
